// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised serial pattern detector, optional match counter (SEQ_DETECT_COUNT_EN)
module seq_detect_param #(
  parameter int          N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b101,
  parameter int          CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          X,
  input  logic          ovl,
  input  logic          clr,
  output logic [N-1:0]  q,
  output logic          Z,
  output logic [CW-1:0] match_cnt
);

  // Fill counter must hold the value N itself.
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [FW-1:0] fill;
  logic [N-1:0]  q_nxt;
  logic [FW-1:0] fill_inc;
  logic [FW-1:0] fill_nxt;
  logic          match;

  // Next history, saturating fill, and match decision for an enabled sample edge.
  always_comb begin
    q_nxt    = {q[N-2:0], X};
    fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
    // Fill gating stops an all-zero pattern from matching the reset history.
    match    = (fill_inc == FILL_FULL) && (q_nxt == PATTERN);
    fill_nxt = (match && !ovl) ? '0 : fill_inc;
  end

  // History, fill and registered match pulse; clear outranks enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      fill <= '0;
      Z    <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      fill <= '0;
      Z    <= 1'b0;
    end else if (en) begin
      q    <= q_nxt;
      fill <= fill_nxt;
      Z    <= match;
    end else begin
      Z    <= 1'b0;
    end
  end

`ifdef SEQ_DETECT_COUNT_EN
  logic [CW-1:0] cnt_r;

  // Saturating count of match edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && match && (cnt_r != {CW{1'b1}})) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign match_cnt = cnt_r;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter N, default 3: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 3'b101 (N bits): target sequence, MSB = oldest bit.
REQ-003 SHALL have parameter CW, default 8: match counter width, legal range 1..16.
REQ-004 SHALL have port clk  input  1: single clock, rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1: sample enable; X is shifted in only when en=1.
REQ-007 SHALL have port X  input  1: serial data bit.
REQ-008 SHALL have port ovl  input  1: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port clr  input  1: synchronous clear of history, fill and counter.
REQ-010 SHALL have port q  output  N: history register, q[0] = newest bit.
REQ-011 SHALL have port Z  output  1: registered match pulse.
REQ-012 SHALL have port match_cnt  output  CW: saturating match count.

Function
REQ-013 SHALL keep internal fill counter, 0..N, counting valid bits collected since reset, clr or a non-overlap match.
REQ-014 On a rising edge with en=1, clr=0: q <= {q[N-2:0], X}; fill <= min(fill+1, N).
REQ-015 A match SHALL exist on that edge when next fill = N and next q = PATTERN.
REQ-016 Z SHALL be 1 for exactly the cycle following the edge that produced a match; otherwise Z = 0.
REQ-017 Latency: Z SHALL rise on the same edge that samples the last pattern bit (one-cycle registered output).
REQ-018 ovl=1: after a match fill stays N, so trailing bits may begin the next match.
REQ-019 ovl=0: after a match fill SHALL be set to 0; q still updates; a fresh N bits are required.
REQ-020 en=0: q, fill and match_cnt SHALL hold; Z SHALL be 0 next cycle.
REQ-021 clr=1 SHALL take priority over en: q <= 0, fill <= 0, Z <= 0, match_cnt <= 0.
REQ-022 Before fill reaches N, no match SHALL be reported even if q happens to equal PATTERN (covers PATTERN = all zeros).
REQ-023 ovl changes SHALL take effect on the next enabled edge; no other state is altered.

Reset
REQ-024 rst=0 SHALL immediately and asynchronously force q = 0, fill = 0, Z = 0, match_cnt = 0.
REQ-025 Reset asserted mid-sequence SHALL discard partial history; detection restarts from fill = 0 after release.
REQ-026 The first enabled edge after rst deasserts SHALL be treated as a normal sample edge.

Configuration
REQ-027 Macro SEQ_DETECT_COUNT_EN: when defined, match_cnt increments on every match edge, saturating at 2^CW-1.
REQ-028 Without SEQ_DETECT_COUNT_EN, match_cnt SHALL be constant 0 and no counter flops SHALL be built; all other behaviour is unchanged.

Verification
REQ-029 N=3, PATTERN=101, ovl=1, en=1: X = 1,0,1,0,1 -> Z high after 3rd and 5th bits; match_cnt = 2 (macro on).
REQ-030 Same stream with ovl=0 -> Z high after 3rd bit only; match_cnt = 1; q = 3'b101 at end.
REQ-031 PATTERN=000 after reset, X = 0,0 -> no Z; third 0 -> Z pulse (fill gating).
REQ-032 X = 1,0, then en=0 for 4 cycles with X toggling, then en=1, X=1 -> Z pulse; q holds 2'b10 in low bits during en=0.
REQ-033 X = 1,0, then rst=0 for one half-cycle, release, X=1 -> no Z; q = 3'b001; clr=1 together with en=1 -> q = 0, match_cnt = 0.
REQ-034 CW=2, macro on, ovl=1, stream 1,0,1,0,1,0,1,0,1 -> 4 matches, match_cnt saturates at 3.
